// File: rtl/mem_pkg.sv
// mem_pkg: shared state encoding, default command layout and default SRAM geometry.
package mem_pkg;
    localparam int DEF_WIDTH = 4;
    localparam int DEF_DEPTH = 32;
    typedef enum logic [1:0] {IDLE, REQ, ACCESS} state_t;
    typedef struct packed {
        logic                         we;
        logic [$clog2(DEF_DEPTH)-1:0] addr;
        logic [DEF_WIDTH-1:0]         wdata;
    } cmd_t;
endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: command queue; pushes while full and pops while empty are ignored.
module cmd_fifo #(
    parameter int  FIFO_DEPTH = 4,
    parameter type T          = logic
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  T     din,
    output T     dout,
    output logic full,
    output logic empty
);
    localparam int PW = $clog2(FIFO_DEPTH);
    T mem [FIFO_DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic [PW:0] count;
    logic do_push, do_pop;
    assign full    = count == (PW+1)'(FIFO_DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr];
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end
    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop) rptr <= rptr + 1'b1;
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: queues SRAM commands and issues one request per two cycles.
// Optional MEM_REQ_STATS_EN adds saturating write/read completion counters.
module mem_req_ctrl import mem_pkg::*; #(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int FIFO_DEPTH = 4,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic [AW-1:0]    cmd_addr,
    input  logic [WIDTH-1:0] cmd_wdata,
    output logic             wr_req,
    output logic             re_req,
    output logic [AW-1:0]    mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
`ifdef MEM_REQ_STATS_EN
    output logic [15:0]      wr_cnt,
    output logic [15:0]      rd_cnt,
`endif
    output logic             busy
);
    typedef struct packed {
        logic             we;
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] wdata;
    } entry_t;
    entry_t cmd_in, head, cmd_q;
    state_t state, state_n;
    logic full, empty, pop, done;
    assign cmd_in    = {cmd_we, cmd_addr, cmd_wdata};
    assign cmd_ready = !full;
    cmd_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .T(entry_t)) u_fifo (
        .clk(clk), .rst(rst), .push(cmd_valid), .pop(pop),
        .din(cmd_in), .dout(head), .full(full), .empty(empty)
    );
    always_comb begin
        pop     = (state != REQ) && !empty;
        state_n = (state == REQ) ? ACCESS : (pop ? REQ : IDLE);
    end
    assign done = state == ACCESS;
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cmd_q    <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            state    <= state_n;
            if (pop) cmd_q <= head;
            rd_valid <= done && !cmd_q.we;
            if (done && !cmd_q.we) rd_data <= mem_rdata;
        end
    end
`ifdef MEM_REQ_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            if (done && cmd_q.we && wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 1'b1;
            if (done && !cmd_q.we && rd_cnt != 16'hFFFF) rd_cnt <= rd_cnt + 1'b1;
        end
    end
`endif
    assign wr_req    = (state == REQ) && cmd_q.we;
    assign re_req    = (state == REQ) && !cmd_q.we;
    assign mem_addr  = cmd_q.addr;
    assign mem_wdata = cmd_q.wdata;
    assign busy      = !empty || (state != IDLE);
endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb_mem_req_ctrl: directed and randomized checks of mem_req_ctrl against a queue-based model.
module tb_mem_req_ctrl;
    localparam int W = 4, D = 32, AW = 5, FD = 4;
    logic clk = 1'b0, rst = 1'b1;
    logic cmd_valid = 1'b0, cmd_we = 1'b0, cmd_ready, wr_req, re_req, rd_valid, busy;
    logic [AW-1:0] cmd_addr = '0, mem_addr;
    logic [W-1:0] cmd_wdata = '0, mem_wdata, mem_rdata, rd_data;
`ifdef MEM_REQ_STATS_EN
    logic [15:0] wr_cnt, rd_cnt;
`endif
    always #5 clk = ~clk;
    mem_req_ctrl #(.WIDTH(W), .DEPTH(D), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .wr_req(wr_req), .re_req(re_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .rd_valid(rd_valid), .rd_data(rd_data),
`ifdef MEM_REQ_STATS_EN
        .wr_cnt(wr_cnt), .rd_cnt(rd_cnt),
`endif
        .busy(busy)
    );
    logic [W-1:0] sram [D];
    always @(posedge clk) if (wr_req) sram[mem_addr] <= mem_wdata;
    assign mem_rdata = sram[mem_addr];
    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [W-1:0]  wdata;
    } mcmd_t;
    // Model: a command leaves the queue whenever no request was issued the cycle before;
    // a request is followed by one access cycle, then a read result appears.
    mcmd_t q[$];
    mcmd_t cur, c1, c2;
    bit r1, r2, e_rdv;
    logic [W-1:0] ref_mem [D];
    logic [W-1:0] rd1, rd2, e_rdata;
    int m_wr, m_rd;
    int n_cmp = 0, n_bad = 0;
    task automatic tick(input logic v, input logic we, input logic [AW-1:0] a, input logic [W-1:0] d);
        bit nr, acc;
        cmd_valid = v; cmd_we = we; cmd_addr = a; cmd_wdata = d;
        @(posedge clk);
        if (rst) begin
            q.delete(); cur = '0; r1 = 0; r2 = 0; e_rdv = 0; e_rdata = '0; m_wr = 0; m_rd = 0;
        end else begin
            nr  = !r1 && q.size() > 0;
            acc = v && q.size() < FD;
            e_rdv = r2 && !c2.we;
            if (e_rdv) e_rdata = rd2;
            if (r2 && c2.we && m_wr < 65535) m_wr++;
            if (r2 && !c2.we && m_rd < 65535) m_rd++;
            if (nr) begin
                cur = q.pop_front();
                if (cur.we) ref_mem[cur.addr] = cur.wdata;
            end
            if (acc) q.push_back(mcmd_t'({we, a, d}));
            r2 = r1; c2 = c1; rd2 = rd1;
            r1 = nr; c1 = cur; rd1 = ref_mem[cur.addr];
        end
        #1;
    endtask
    task automatic drain();
        int k = 0;
        while (busy && k < 40) begin tick(0, 0, '0, '0); k++; end
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL drain: busy=%b after %0d cycles, want 0", busy, k); end
    endtask
    task automatic test_reset();
        rst = 1'b1;
        tick(1, 1, 5'd3, 4'h7);
        tick(1, 0, 5'd9, 4'h2);
        n_cmp++;
        if ({cmd_ready, busy, wr_req, re_req, rd_valid, rd_data, mem_addr, mem_wdata} !== {5'b10000, 4'h0, 5'h0, 4'h0}) begin
            n_bad++; $display("FAIL reset_in: got %b", {cmd_ready, busy, wr_req, re_req, rd_valid, rd_data, mem_addr, mem_wdata});
        end
        rst = 1'b0;
        tick(0, 0, '0, '0);
        n_cmp++;
        if ({cmd_ready, busy, wr_req, re_req, rd_valid, rd_data, mem_addr, mem_wdata} !== {5'b10000, 4'h0, 5'h0, 4'h0}) begin
            n_bad++; $display("FAIL reset_after: got %b", {cmd_ready, busy, wr_req, re_req, rd_valid, rd_data, mem_addr, mem_wdata});
        end
    endtask
    task automatic test_single_write();
        drain();
        tick(1, 1, 5'd5, 4'hA);
        tick(0, 0, '0, '0);
        n_cmp++;
        if ({wr_req, re_req, mem_addr, mem_wdata} !== {2'b10, 5'd5, 4'hA}) begin
            n_bad++; $display("FAIL single_write_req: got %b, want %b", {wr_req, re_req, mem_addr, mem_wdata}, {2'b10, 5'd5, 4'hA});
        end
        tick(0, 0, '0, '0);
        n_cmp++;
        if ({wr_req, re_req, rd_valid, mem_addr, mem_wdata} !== {3'b000, 5'd5, 4'hA}) begin
            n_bad++; $display("FAIL single_write_access: got %b", {wr_req, re_req, rd_valid, mem_addr, mem_wdata});
        end
        tick(0, 0, '0, '0);
        n_cmp++;
        if ({rd_valid, busy, mem_addr, mem_wdata} !== {2'b00, 5'd5, 4'hA}) begin
            n_bad++; $display("FAIL single_write_done: got %b", {rd_valid, busy, mem_addr, mem_wdata});
        end
    endtask
    task automatic test_readback();
        int k = 0;
        drain();
        tick(1, 1, 5'd5, 4'hA);
        tick(1, 0, 5'd5, 4'h0);
        while (!re_req && k < 8) begin tick(0, 0, '0, '0); k++; end
        n_cmp++;
        if (re_req !== 1'b1) begin n_bad++; $display("FAIL readback_req: re_req=%b after %0d cycles, want 1", re_req, k); end
        tick(0, 0, '0, '0);
        n_cmp++;
        if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL readback_early: rd_valid=%b want 0", rd_valid); end
        tick(0, 0, '0, '0);
        n_cmp++;
        if ({rd_valid, rd_data} !== {1'b1, 4'hA}) begin
            n_bad++; $display("FAIL readback_data: rd_valid=%b rd_data=%h, want 1 A", rd_valid, rd_data);
        end
        tick(0, 0, '0, '0);
        n_cmp++;
        if ({rd_valid, rd_data} !== {1'b0, 4'hA}) begin
            n_bad++; $display("FAIL readback_hold: rd_valid=%b rd_data=%h, want 0 A", rd_valid, rd_data);
        end
    endtask
    task automatic test_full();
        logic [AW-1:0] seen[$];
        int k = 0;
        drain();
        for (int i = 0; i < 8; i++) begin
            if (i < 7) tick(1, 1, AW'(i), W'(i));
            else tick(1, 1, 5'd31, 4'hF);
            if (wr_req) seen.push_back(mem_addr);
            n_cmp++;
            if (cmd_ready !== (i != 6)) begin
                n_bad++; $display("FAIL full_ready[%0d]: cmd_ready=%b want %b", i, cmd_ready, i != 6);
            end
        end
        while (busy && k < 40) begin
            tick(0, 0, '0, '0);
            if (wr_req) seen.push_back(mem_addr);
            k++;
        end
        n_cmp++;
        if (seen.size() != 7) begin n_bad++; $display("FAIL full_count: %0d writes issued, want 7", seen.size()); end
        for (int i = 0; i < seen.size(); i++) begin
            n_cmp++;
            if (seen[i] !== AW'(i)) begin n_bad++; $display("FAIL full_order[%0d]: addr=%0d want %0d", i, seen[i], i); end
        end
    endtask
    task automatic test_push_pop();
        drain();
        tick(1, 1, 5'd1, 4'h1);
        tick(1, 0, 5'd2, 4'h0);
        n_cmp++;
        if ({wr_req, re_req, mem_addr} !== {2'b10, 5'd1}) begin n_bad++; $display("FAIL pp_first: got %b", {wr_req, re_req, mem_addr}); end
        tick(1, 1, 5'd3, 4'h3);
        tick(1, 0, 5'd4, 4'h0);
        n_cmp++;
        if ({wr_req, re_req, mem_addr, cmd_ready} !== {2'b01, 5'd2, 1'b1}) begin
            n_bad++; $display("FAIL pp_same_edge: got %b", {wr_req, re_req, mem_addr, cmd_ready});
        end
        tick(0, 0, '0, '0);
        tick(0, 0, '0, '0);
        n_cmp++;
        if ({wr_req, re_req, mem_addr} !== {2'b10, 5'd3}) begin n_bad++; $display("FAIL pp_third: got %b", {wr_req, re_req, mem_addr}); end
        tick(0, 0, '0, '0);
        tick(0, 0, '0, '0);
        n_cmp++;
        if ({wr_req, re_req, mem_addr} !== {2'b01, 5'd4}) begin n_bad++; $display("FAIL pp_fourth: got %b", {wr_req, re_req, mem_addr}); end
        tick(0, 0, '0, '0);
        tick(0, 0, '0, '0);
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL pp_idle: busy=%b want 0", busy); end
    endtask
    task automatic test_reset_mid_read();
        drain();
        tick(1, 0, 5'd7, 4'h0);
        tick(1, 1, 5'd2, 4'h2);
        tick(1, 1, 5'd3, 4'h3);
        rst = 1'b1;
        tick(0, 0, '0, '0);
        rst = 1'b0;
        n_cmp++;
        if ({rd_valid, busy, cmd_ready} !== 3'b001) begin
            n_bad++; $display("FAIL rst_mid: rd_valid busy cmd_ready=%b want 001", {rd_valid, busy, cmd_ready});
        end
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, '0, '0);
            n_cmp++;
            if ({rd_valid, wr_req, re_req, busy} !== 4'b0000) begin
                n_bad++; $display("FAIL rst_mid_after[%0d]: rd_valid wr re busy=%b want 0000", i, {rd_valid, wr_req, re_req, busy});
            end
        end
    endtask
    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            tick($urandom_range(0, 9) < 7, $urandom_range(0, 1), AW'($urandom), W'($urandom));
            n_cmp++;
            if ({wr_req, re_req} !== {r1 && c1.we, r1 && !c1.we}) begin
                n_bad++; $display("FAIL rand_req[%0d]: wr re=%b%b want %b%b", i, wr_req, re_req, r1 && c1.we, r1 && !c1.we);
            end
            n_cmp++;
            if ({mem_addr, mem_wdata} !== {cur.addr, cur.wdata}) begin
                n_bad++; $display("FAIL rand_mem[%0d]: addr=%0d wdata=%h want %0d %h", i, mem_addr, mem_wdata, cur.addr, cur.wdata);
            end
            n_cmp++;
            if ({busy, cmd_ready} !== {q.size() > 0 || r1 || r2, q.size() < FD}) begin
                n_bad++; $display("FAIL rand_flow[%0d]: busy ready=%b%b want %b%b", i, busy, cmd_ready, q.size() > 0 || r1 || r2, q.size() < FD);
            end
            n_cmp++;
            if ({rd_valid, rd_data} !== {e_rdv, e_rdata}) begin
                n_bad++; $display("FAIL rand_rd[%0d]: rd_valid=%b rd_data=%h want %b %h", i, rd_valid, rd_data, e_rdv, e_rdata);
            end
`ifdef MEM_REQ_STATS_EN
            n_cmp++;
            if ({wr_cnt, rd_cnt} !== {16'(m_wr), 16'(m_rd)}) begin
                n_bad++; $display("FAIL rand_cnt[%0d]: wr=%0d rd=%0d want %0d %0d", i, wr_cnt, rd_cnt, m_wr, m_rd);
            end
`endif
        end
        rst = 1'b0;
    endtask
`ifdef MEM_REQ_STATS_EN
    task automatic test_stats();
        rst = 1'b1;
        tick(0, 0, '0, '0);
        rst = 1'b0;
        tick(1, 1, 5'd1, 4'h1);
        tick(1, 0, 5'd1, 4'h0);
        tick(1, 1, 5'd2, 4'h2);
        tick(1, 0, 5'd2, 4'h0);
        tick(1, 1, 5'd3, 4'h3);
        drain();
        n_cmp++;
        if ({wr_cnt, rd_cnt} !== {16'd3, 16'd2}) begin n_bad++; $display("FAIL stats_count: wr=%0d rd=%0d want 3 2", wr_cnt, rd_cnt); end
        force dut.wr_cnt = 16'hFFFF;
        tick(0, 0, '0, '0);
        release dut.wr_cnt;
        tick(1, 1, 5'd4, 4'h4);
        drain();
        n_cmp++;
        if (wr_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL stats_sat: wr_cnt=%h want FFFF", wr_cnt); end
    endtask
`endif
    initial begin
        for (int i = 0; i < D; i++) begin
            sram[i] = W'($urandom);
            ref_mem[i] = sram[i];
        end
        test_reset();
        test_single_write();
        test_readback();
        test_full();
        test_push_pop();
        test_reset_mid_read();
        test_random();
`ifdef MEM_REQ_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_req_ctrl.md
MEM_REQ_CTRL -- requirements
Module: mem_req_ctrl

Interface
REQ-001 Parameter WIDTH, default 4, SRAM data width in bits.
REQ-002 Parameter DEPTH, default 32, SRAM word count; AW = $clog2(DEPTH).
REQ-003 Parameter FIFO_DEPTH, default 4, command FIFO entries; power of two, at least 2.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 cmd_valid  in  1  upstream command present.
REQ-007 cmd_ready  out  1  command FIFO can accept.
REQ-008 cmd_we  in  1  1 = write, 0 = read.
REQ-009 cmd_addr  in  AW  target word address.
REQ-010 cmd_wdata  in  WIDTH  write data; ignored for reads.
REQ-011 wr_req  out  1  one-cycle write request to the SRAM control FSM.
REQ-012 re_req  out  1  one-cycle read request to the SRAM control FSM.
REQ-013 mem_addr  out  AW  SRAM address.
REQ-014 mem_wdata  out  WIDTH  SRAM write data.
REQ-015 mem_rdata  in  WIDTH  SRAM read data; valid while oe is high.
REQ-016 rd_valid  out  1  one-cycle pulse; rd_data holds a read result.
REQ-017 rd_data  out  WIDTH  read result.
REQ-018 busy  out  1  high when the FIFO is non-empty or the FSM is not in IDLE.

Function
REQ-019 Push: the block SHALL push when cmd_valid && cmd_ready; cmd_ready = !full, taken from registered count only.
REQ-020 States: IDLE, REQ, ACCESS.
REQ-021 IDLE -> REQ when the FIFO is non-empty; that same edge pops the head into the command register.
REQ-022 REQ: the block SHALL assert exactly one of wr_req/re_req (per cmd_we) for one cycle; next state is ACCESS.
REQ-023 ACCESS matches the SRAM FSM WRITE/READ cycle. Exit to REQ (with pop) if the FIFO is non-empty, otherwise to IDLE.
REQ-024 mem_addr and mem_wdata SHALL come from the command register and hold steady through REQ and ACCESS.
REQ-025 Read capture: mem_rdata is registered into rd_data at the edge leaving ACCESS; rd_valid is high for the following cycle only. rd_data holds its value otherwise.
REQ-026 Latency: for a command accepted at edge 0 with the block in IDLE and the FIFO empty:
- request high between edges 1 and 2;
- access between edges 2 and 3;
- rd_valid high between edges 3 and 4.
REQ-027 Throughput: one command per 2 cycles; commands SHALL execute in FIFO order.
REQ-028 Push and pop in the same cycle SHALL be legal when not full; count is unchanged.
REQ-029 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-030 A push attempted while full is ignored; FIFO contents are unaffected.

Reset
REQ-031 On rst the block SHALL go to IDLE and flush the FIFO (count 0, pointers 0). The command register clears to 0.
REQ-032 Output values during reset: cmd_ready=1 after reset, wr_req=re_req=rd_valid=busy=0, rd_data=0, mem_addr=0, mem_wdata=0.
REQ-033 An in-flight command at reset is discarded with no rd_valid; the SRAM FSM shares rst.

Configuration
REQ-034 Macro MEM_REQ_STATS_EN. When defined, the block SHALL add:
- outputs wr_cnt[15:0] and rd_cnt[15:0];
- each increments at the edge leaving ACCESS for a write or a read respectively;
- each saturates at 16'hFFFF and clears on rst.
REQ-035 Without MEM_REQ_STATS_EN, these ports and counters SHALL be absent; all other behaviour is identical.

Structure
REQ-036 Shared package mem_pkg holds:
- the state typedef (IDLE, REQ, ACCESS);
- the command struct typedef (we, addr, wdata);
- the default WIDTH and DEPTH constants.
REQ-037 Sub-module cmd_fifo (parameters FIFO_DEPTH and entry type) holds the FIFO storage, pointers, count, full and empty. mem_req_ctrl instantiates it once.

Verification
REQ-038 Single write: push we=1, addr=5, wdata=4'hA at edge 0 -> wr_req=1 between edges 1 and 2, mem_addr=5, mem_wdata=A through edge 3, no rd_valid.
REQ-039 Read-back: write addr=5 data=A, then read addr=5 with the SRAM model attached -> rd_valid one cycle, rd_data=4'hA, 2 cycles after the read's re_req.
REQ-040 Full: push 5 commands back-to-back while the first stalls in IDLE->REQ -> cmd_ready=0 after the 4th queued entry, 5th accepted only after a pop, order preserved.
REQ-041 Simultaneous push/pop: push at the same edge as the ACCESS->REQ pop with count=2 -> count stays 2, next request issues at the following cycle.
REQ-042 Reset mid-ACCESS of a read: assert rst -> no rd_valid, FIFO empty, busy=0, cmd_ready=1 after the reset edge.
REQ-043 With MEM_REQ_STATS_EN: 3 writes and 2 reads -> wr_cnt=3, rd_cnt=2; force a counter to FFFF and complete one more write -> it stays FFFF.
